// File: rtl/slink_apb_tgt.sv
// APB target bridge for S-Link: turns local APB transfers into S-Link request
// packets and completes them with the far-end response, timeout or disable error.

module slink_demet_reset (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_out
);
  logic meta;

  // NOTE: non-blocking assignments so each flop samples the value from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      sig_out <= 1'b0;
    end else begin
      meta    <= sig_in;
      sig_out <= meta;
    end
  end
endmodule

// Two-entry gray-pointer async FIFO, first-word fall-through on the read side.
module slink_apb_tgt_afifo #(
  parameter int W = 8
) (
  input  logic         wclk,
  input  logic         wreset,
  input  logic         wen,
  input  logic [W-1:0] wdata,
  output logic         full,
  input  logic         rclk,
  input  logic         rreset,
  input  logic         ren,
  output logic [W-1:0] rdata,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic [1:0]   wbin, wgray, rq1, rq2, wbin_nx;
  logic [1:0]   rbin, rgray, wq1, wq2, rbin_nx;

  assign wbin_nx = wbin + 2'd1;
  assign rbin_nx = rbin + 2'd1;
  assign full    = (wgray == ~rq2);
  assign empty   = (rgray == wq2);
  assign rdata   = mem[rbin[0]];

  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      wbin  <= '0;
      wgray <= '0;
      rq1   <= '0;
      rq2   <= '0;
    end else begin
      rq1 <= rgray;
      rq2 <= rq1;
      if (wen && !full) begin
        wbin  <= wbin_nx;
        wgray <= wbin_nx ^ (wbin_nx >> 1);
      end
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge wclk) begin
    if (wen && !full) mem[wbin[0]] <= wdata;
  end

  always_ff @(posedge rclk or posedge rreset) begin
    if (rreset) begin
      rbin  <= '0;
      rgray <= '0;
      wq1   <= '0;
      wq2   <= '0;
    end else begin
      wq1 <= wgray;
      wq2 <= wq1;
      if (ren && !empty) begin
        rbin  <= rbin_nx;
        rgray <= rbin_nx ^ (rbin_nx >> 1);
      end
    end
  end
endmodule

// Clock crossing and packetization between the APB-side state machine and the link.
module slink_generic_fc_sm #(
  parameter int A2L_DATA_WIDTH    = 88,
  parameter int L2A_DATA_WIDTH    = 57,
  parameter int TX_APP_DATA_WIDTH = 128,
  parameter int RX_APP_DATA_WIDTH = 128
) (
  input  logic                         app_clk,
  input  logic                         app_reset,
  input  logic                         link_clk,
  input  logic                         link_reset,
  input  logic [7:0]                   swi_cr_id,
  input  logic [7:0]                   swi_crack_id,
  input  logic [7:0]                   swi_ack_id,
  input  logic [7:0]                   swi_nack_id,
  input  logic [7:0]                   swi_data_id,
  input  logic [15:0]                  swi_word_count,
  input  logic                         a2l_valid,
  output logic                         a2l_ready,
  input  logic [A2L_DATA_WIDTH-1:0]    a2l_data,
  output logic                         l2a_valid,
  input  logic                         l2a_accept,
  output logic [L2A_DATA_WIDTH-1:0]    l2a_data,
  output logic                         tx_sop,
  output logic [7:0]                   tx_data_id,
  output logic [15:0]                  tx_word_count,
  output logic [TX_APP_DATA_WIDTH-1:0] tx_app_data,
  input  logic                         tx_advance,
  input  logic                         rx_sop,
  input  logic [7:0]                   rx_data_id,
  input  logic [15:0]                  rx_word_count,
  input  logic [RX_APP_DATA_WIDTH-1:0] rx_app_data,
  input  logic                         rx_valid,
  input  logic                         rx_crc_corrupted,
  output logic                         nack_sent,
  output logic                         nack_seen
);
  logic [A2L_DATA_WIDTH-1:0] tx_q;
  logic a2l_full, tx_empty, l2a_empty, rx_full;
  logic rx_pkt, rx_ctrl, rx_push, unused_rx;

  slink_apb_tgt_afifo #(.W(A2L_DATA_WIDTH)) u_a2l (
    .wclk(app_clk), .wreset(app_reset), .wen(a2l_valid), .wdata(a2l_data), .full(a2l_full),
    .rclk(link_clk), .rreset(link_reset), .ren(tx_sop && tx_advance), .rdata(tx_q),
    .empty(tx_empty)
  );

  assign a2l_ready     = !a2l_full;
  assign tx_sop        = !tx_empty;
  // The low bits of the app word carry DT/WC unless software overrides them.
  assign tx_data_id    = (swi_data_id == 8'hff) ? tx_q[7:0] : swi_data_id;
  assign tx_word_count = (swi_word_count == 16'd0) ? tx_q[23:8] : swi_word_count;
  assign tx_app_data   = TX_APP_DATA_WIDTH'(tx_q[A2L_DATA_WIDTH-1:24]);

  assign rx_pkt  = rx_sop && rx_valid;
  assign rx_ctrl = (rx_data_id == swi_cr_id) || (rx_data_id == swi_crack_id) ||
                   (rx_data_id == swi_ack_id) || (rx_data_id == swi_nack_id);
  assign rx_push = rx_pkt && !rx_crc_corrupted && !rx_ctrl;
  assign unused_rx = ^{rx_app_data[RX_APP_DATA_WIDTH-1:L2A_DATA_WIDTH-24], rx_full};

  slink_apb_tgt_afifo #(.W(L2A_DATA_WIDTH)) u_l2a (
    .wclk(link_clk), .wreset(link_reset), .wen(rx_push),
    .wdata({rx_app_data[L2A_DATA_WIDTH-25:0], rx_word_count, rx_data_id}), .full(rx_full),
    .rclk(app_clk), .rreset(app_reset), .ren(l2a_accept), .rdata(l2a_data),
    .empty(l2a_empty)
  );

  assign l2a_valid = !l2a_empty;

  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      nack_sent <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      nack_sent <= rx_pkt && rx_crc_corrupted;
      nack_seen <= rx_pkt && !rx_crc_corrupted && (rx_data_id == swi_nack_id);
    end
  end
endmodule

module slink_apb_tgt #(
  parameter int         TX_APP_DATA_WIDTH = 128,
  parameter int         RX_APP_DATA_WIDTH = 128,
  parameter logic [7:0] APB_READ_DT       = 8'h24,
  parameter logic [7:0] APB_READ_RSP_DT   = 8'h25,
  parameter logic [7:0] APB_WRITE_DT      = 8'h26,
  parameter logic [7:0] APB_WRITE_RSP_DT  = 8'h27
) (
  input  logic                         apb_clk,
  input  logic                         apb_reset,
  input  logic [31:0]                  apb_paddr,
  input  logic                         apb_pwrite,
  input  logic                         apb_psel,
  input  logic                         apb_penable,
  input  logic [31:0]                  apb_pwdata,
  output logic [31:0]                  apb_prdata,
  output logic                         apb_pready,
  output logic                         apb_pslverr,
  input  logic                         enable,
  input  logic [7:0]                   swi_cr_id,
  input  logic [7:0]                   swi_crack_id,
  input  logic [7:0]                   swi_ack_id,
  input  logic [7:0]                   swi_nack_id,
  input  logic [15:0]                  swi_timeout,
  output logic                         nack_sent,
  output logic                         nack_seen,
  output logic                         invalid_resp_pkt,
  output logic                         timeout_err,
  input  logic                         link_clk,
  input  logic                         link_reset,
  output logic                         tx_sop,
  output logic [7:0]                   tx_data_id,
  output logic [15:0]                  tx_word_count,
  output logic [TX_APP_DATA_WIDTH-1:0] tx_app_data,
  input  logic                         tx_advance,
  input  logic                         rx_sop,
  input  logic [7:0]                   rx_data_id,
  input  logic [15:0]                  rx_word_count,
  input  logic [RX_APP_DATA_WIDTH-1:0] rx_app_data,
  input  logic                         rx_valid,
  input  logic                         rx_crc_corrupted
);
  typedef enum logic [1:0] {IDLE, SEND_REQ, WAIT_RSP, DONE} state_t;

  state_t      state;
  logic [31:0] req_addr, req_wdata;
  logic        req_write;
  logic [15:0] timer;
  logic        enable_apb_clk;
  logic        a2l_valid, a2l_ready, l2a_valid, l2a_accept;
  logic [87:0] a2l_data;
  logic [56:0] l2a_data;
  logic [7:0]  exp_dt;
  logic [15:0] unused_wc;

  slink_demet_reset u_enable_sync (
    .clk(apb_clk), .reset(apb_reset), .sig_in(enable), .sig_out(enable_apb_clk)
  );

  assign a2l_data   = req_write ? {req_wdata, req_addr, 16'd8, APB_WRITE_DT}
                                : {32'd0, req_addr, 16'd4, APB_READ_DT};
  assign exp_dt     = req_write ? APB_WRITE_RSP_DT : APB_READ_RSP_DT;
  // Every response is consumed at once; the state decides whether it is used or dropped.
  assign l2a_accept = l2a_valid;
  assign unused_wc  = l2a_data[23:8];

  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      state            <= IDLE;
      req_addr         <= '0;
      req_wdata        <= '0;
      req_write        <= 1'b0;
      timer            <= '0;
      a2l_valid        <= 1'b0;
      apb_pready       <= 1'b0;
      apb_prdata       <= '0;
      apb_pslverr      <= 1'b0;
      invalid_resp_pkt <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      invalid_resp_pkt <= l2a_valid && (state != WAIT_RSP);
      timeout_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (apb_psel && !apb_penable) begin
            req_addr  <= apb_paddr;
            req_wdata <= apb_pwdata;
            req_write <= apb_pwrite;
            if (enable_apb_clk) begin
              state     <= SEND_REQ;
              a2l_valid <= 1'b1;
            end else begin
              state       <= DONE;
              apb_pready  <= 1'b1;
              apb_prdata  <= '0;
              apb_pslverr <= 1'b1;
            end
          end
        end
        SEND_REQ: begin
          if (a2l_ready) begin
            a2l_valid <= 1'b0;
            timer     <= '0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (l2a_valid) begin
            if (l2a_data[7:0] == exp_dt) begin
              state       <= DONE;
              apb_pready  <= 1'b1;
              apb_prdata  <= req_write ? 32'd0 : l2a_data[55:24];
              apb_pslverr <= req_write ? l2a_data[24] : l2a_data[56];
            end else begin
              invalid_resp_pkt <= 1'b1;
            end
          end else if ((swi_timeout != 16'd0) && (timer == swi_timeout)) begin
            state       <= DONE;
            apb_pready  <= 1'b1;
            apb_prdata  <= '0;
            apb_pslverr <= 1'b1;
            timeout_err <= 1'b1;
          end else if (timer != '1) begin
            timer <= timer + 16'd1;
          end
        end
        DONE: begin
          state       <= IDLE;
          apb_pready  <= 1'b0;
          apb_prdata  <= '0;
          apb_pslverr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  slink_generic_fc_sm #(
    .A2L_DATA_WIDTH(88), .L2A_DATA_WIDTH(57),
    .TX_APP_DATA_WIDTH(TX_APP_DATA_WIDTH), .RX_APP_DATA_WIDTH(RX_APP_DATA_WIDTH)
  ) u_fc_sm (
    .app_clk(apb_clk), .app_reset(apb_reset), .link_clk(link_clk), .link_reset(link_reset),
    .swi_cr_id(swi_cr_id), .swi_crack_id(swi_crack_id), .swi_ack_id(swi_ack_id),
    .swi_nack_id(swi_nack_id), .swi_data_id(8'hff), .swi_word_count(16'd0),
    .a2l_valid(a2l_valid), .a2l_ready(a2l_ready), .a2l_data(a2l_data),
    .l2a_valid(l2a_valid), .l2a_accept(l2a_accept), .l2a_data(l2a_data),
    .tx_sop(tx_sop), .tx_data_id(tx_data_id), .tx_word_count(tx_word_count),
    .tx_app_data(tx_app_data), .tx_advance(tx_advance),
    .rx_sop(rx_sop), .rx_data_id(rx_data_id), .rx_word_count(rx_word_count),
    .rx_app_data(rx_app_data), .rx_valid(rx_valid), .rx_crc_corrupted(rx_crc_corrupted),
    .nack_sent(nack_sent), .nack_seen(nack_seen)
  );
endmodule

// File: tb/tb_slink_apb_tgt.sv
// Bench for slink_apb_tgt: APB master, far-end link responder and a memory
// model of the remote target.

module tb_slink_apb_tgt;
  logic         apb_clk = 1'b0, link_clk = 1'b0;
  logic         apb_reset, link_reset;
  logic [31:0]  apb_paddr, apb_pwdata, apb_prdata;
  logic         apb_pwrite, apb_psel, apb_penable, apb_pready, apb_pslverr;
  logic         enable;
  logic [7:0]   swi_cr_id, swi_crack_id, swi_ack_id, swi_nack_id;
  logic [15:0]  swi_timeout;
  logic         nack_sent, nack_seen, invalid_resp_pkt, timeout_err;
  logic         tx_sop, tx_advance;
  logic [7:0]   tx_data_id, rx_data_id;
  logic [15:0]  tx_word_count, rx_word_count;
  logic [127:0] tx_app_data, rx_app_data;
  logic         rx_sop, rx_valid, rx_crc_corrupted;

  always #5 apb_clk  = ~apb_clk;
  always #3 link_clk = ~link_clk;

  slink_apb_tgt dut (
    .apb_clk(apb_clk), .apb_reset(apb_reset), .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .enable(enable), .swi_cr_id(swi_cr_id), .swi_crack_id(swi_crack_id),
    .swi_ack_id(swi_ack_id), .swi_nack_id(swi_nack_id), .swi_timeout(swi_timeout),
    .nack_sent(nack_sent), .nack_seen(nack_seen), .invalid_resp_pkt(invalid_resp_pkt),
    .timeout_err(timeout_err), .link_clk(link_clk), .link_reset(link_reset),
    .tx_sop(tx_sop), .tx_data_id(tx_data_id), .tx_word_count(tx_word_count),
    .tx_app_data(tx_app_data), .tx_advance(tx_advance), .rx_sop(rx_sop),
    .rx_data_id(rx_data_id), .rx_word_count(rx_word_count), .rx_app_data(rx_app_data),
    .rx_valid(rx_valid), .rx_crc_corrupted(rx_crc_corrupted)
  );

  typedef struct { logic [7:0] dt; logic [31:0] data; logic err; int gap; } rsp_t;
  typedef struct { logic [7:0] dt; logic [15:0] wc; logic [127:0] pay; } txpkt_t;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata;
    logic [7:0] rdt; logic [31:0] rdata; logic rerr;
    logic [31:0] exp_rdata; logic exp_err;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int n_pready = 0, n_invalid = 0, n_tmo = 0;
  rsp_t   inj_q[$], pend_q[$];
  txpkt_t tx_q[$];
  bit auto_rsp = 0, adv_hold = 0, adv_rand = 0;
  logic [31:0] far_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  always @(posedge apb_clk) begin
    if (apb_pready)       n_pready++;
    if (invalid_resp_pkt) n_invalid++;
    if (timeout_err)      n_tmo++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Remote target behaviour: error on offset 0xC, unwritten reads return a pattern.
  function automatic logic rule_err(input logic [31:0] a);
    return a[3:0] == 4'hC;
  endfunction
  function automatic logic [31:0] rule_dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic rsp_t mk_rsp(input logic [7:0] dt, input logic [31:0] d,
                                  input logic e, input int gap);
    rsp_t r;
    r.dt = dt; r.data = d; r.err = e; r.gap = gap;
    return r;
  endfunction

  // Far end: consumes TX packets, optionally auto-answers, and replays queued responses.
  initial begin
    tx_advance = 1'b1; rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
    rx_data_id = '0; rx_word_count = '0; rx_app_data = '0;
    forever begin
      @(negedge link_clk);
      tx_advance = !adv_hold && (!adv_rand || ($urandom_range(0, 3) != 0));
      if (tx_sop && tx_advance && !link_reset) begin
        txpkt_t p;
        rsp_t   r;
        logic [31:0] a;
        p.dt = tx_data_id; p.wc = tx_word_count; p.pay = tx_app_data;
        tx_q.push_back(p);
        if (auto_rsp) begin
          a = p.pay[31:0];
          if (p.dt == 8'h26) begin
            far_mem[a] = p.pay[63:32];
            r = mk_rsp(8'h27, 32'd0, rule_err(a), $urandom_range(0, 4));
          end else begin
            r = mk_rsp(8'h25, far_mem.exists(a) ? far_mem[a] : rule_dflt(a), rule_err(a),
                       $urandom_range(0, 4));
          end
          inj_q.push_back(r);
        end
      end
      rx_sop = 1'b0; rx_valid = 1'b0; rx_data_id = '0; rx_app_data = '0;
      if (inj_q.size() > 0) begin
        if (inj_q[0].gap > 0) begin
          inj_q[0].gap = inj_q[0].gap - 1;
        end else begin
          rsp_t r;
          r = inj_q.pop_front();
          rx_sop = 1'b1; rx_valid = 1'b1; rx_data_id = r.dt; rx_word_count = 16'd4;
          if (r.dt == 8'h27) rx_app_data[0] = r.err;
          else begin
            rx_app_data[31:0] = r.data;
            rx_app_data[32]   = r.err;
          end
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int cyc);
    @(negedge apb_clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr; apb_paddr = a; apb_pwdata = wd;
    @(negedge apb_clk);
    apb_penable = 1'b1;
    cyc = 1;
    while (!apb_pready && cyc < 3000) begin
      @(negedge apb_clk);
      cyc++;
    end
    rd = apb_prdata; er = apb_pslverr;
    check("xfer_completes", apb_pready, 1);
    @(negedge apb_clk);
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  task automatic wait_tx();
    int k = 0;
    while (tx_q.size() == 0 && k < 500) begin
      @(negedge apb_clk);
      k++;
    end
  endtask

  task automatic xfer_manual(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int cyc);
    fork
      apb_xfer(wr, a, wd, rd, er, cyc);
      begin
        wait_tx();
        while (pend_q.size() > 0) inj_q.push_back(pend_q.pop_front());
      end
    join
  endtask

  task automatic check_tx(input string name, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd);
    txpkt_t p;
    if (tx_q.size() == 0) begin
      check({name, "_tx_present"}, 0, 1);
    end else begin
      p = tx_q.pop_front();
      check({name, "_tx_dt_wc"}, {p.dt, p.wc}, wr ? {8'h26, 16'd8} : {8'h24, 16'd4});
      check({name, "_tx_payload"}, p.pay, {64'd0, (wr ? wd : 32'd0), a});
    end
  endtask

  initial begin
    vec_t vt[4];
    logic [31:0] rd, a, wd, exp_rd;
    logic er, wr;
    int cyc, base_rdy, base_inv, base_tmo;
    bit done;

    vt[0] = '{1'b1, 32'h1000_0040, 32'hA5A5_5A5A, 8'h27, 32'h0, 1'b0, 32'h0, 1'b0};
    vt[1] = '{1'b0, 32'h2000_0004, 32'h0, 8'h25, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1};
    vt[2] = '{1'b1, 32'h3000_0008, 32'h1234_5678, 8'h27, 32'h0, 1'b1, 32'h0, 1'b1};
    vt[3] = '{1'b0, 32'h4000_000C, 32'h0, 8'h25, 32'h0BAD_BEEF, 1'b0, 32'h0BAD_BEEF, 1'b0};

    apb_reset = 1'b1; link_reset = 1'b1; enable = 1'b1; swi_timeout = 16'd0;
    swi_cr_id = 8'h01; swi_crack_id = 8'h02; swi_ack_id = 8'h03; swi_nack_id = 8'h04;
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = '0; apb_pwdata = '0;
    repeat (4) @(negedge apb_clk);
    check("rst_pready", apb_pready, 0);
    check("rst_prdata", apb_prdata, 0);
    check("rst_pslverr", apb_pslverr, 0);
    check("rst_pulses", {invalid_resp_pkt, timeout_err}, 0);
    check("rst_tx_sop", tx_sop, 0);
    apb_reset = 1'b0; link_reset = 1'b0;
    repeat (5) @(negedge apb_clk);

    // Directed vectors with hand-picked far-end responses.
    foreach (vt[i]) begin
      base_rdy = n_pready;
      pend_q.push_back(mk_rsp(vt[i].rdt, vt[i].rdata, vt[i].rerr, 2));
      xfer_manual(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, cyc);
      check($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_pslverr", i), er, vt[i].exp_err);
      check($sformatf("vec%0d_pready_once", i), n_pready - base_rdy, 1);
      check($sformatf("vec%0d_min_latency", i), cyc >= 3, 1);
      check_tx($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata);
    end

    // Mismatched DT is dropped while the read keeps waiting for its own response.
    base_inv = n_invalid;
    pend_q.push_back(mk_rsp(8'h27, 32'h0, 1'b1, 2));
    pend_q.push_back(mk_rsp(8'h25, 32'h600D_F00D, 1'b0, 3));
    xfer_manual(1'b0, 32'h2000_0010, 32'h0, rd, er, cyc);
    check("baddt_invalid_pulse", n_invalid - base_inv, 1);
    check("baddt_prdata", rd, 32'h600D_F00D);
    check("baddt_pslverr", er, 0);
    check_tx("baddt", 1'b0, 32'h2000_0010, 32'h0);

    // Timeout with no response, then a late response that must be discarded.
    swi_timeout = 16'd16;
    base_tmo = n_tmo; base_inv = n_invalid;
    xfer_manual(1'b0, 32'h7000_0000, 32'h0, rd, er, cyc);
    check("tmo_latency", cyc, 16 + 3);
    check("tmo_pslverr", er, 1);
    check("tmo_prdata", rd, 0);
    check("tmo_pulse", n_tmo - base_tmo, 1);
    check_tx("tmo", 1'b0, 32'h7000_0000, 32'h0);
    base_rdy = n_pready;
    inj_q.push_back(mk_rsp(8'h25, 32'hDEAD_0001, 1'b0, 0));
    repeat (30) @(negedge apb_clk);
    check("late_invalid_pulse", n_invalid - base_inv, 1);
    check("late_no_pready", n_pready - base_rdy, 0);
    swi_timeout = 16'd0;

    // Disabled block completes with an error one cycle after setup.
    enable = 1'b0;
    repeat (4) @(negedge apb_clk);
    apb_xfer(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, rd, er, cyc);
    check("dis_latency", cyc, 1);
    check("dis_pslverr", er, 1);
    check("dis_prdata", rd, 0);
    apb_xfer(1'b0, 32'h1000_0004, 32'h0, rd, er, cyc);
    check("dis_rd_pslverr", er, 1);
    repeat (20) @(negedge apb_clk);
    check("dis_no_tx", tx_q.size(), 0);
    enable = 1'b1;
    repeat (4) @(negedge apb_clk);

    // Link back-pressure: nothing completes while tx_advance is held low.
    auto_rsp = 1; adv_hold = 1; done = 0;
    base_rdy = n_pready;
    fork
      begin
        apb_xfer(1'b1, 32'h5000_0010, 32'h0F0F_1234, rd, er, cyc);
        done = 1;
      end
      begin
        repeat (50) @(negedge apb_clk);
        check("stall_no_pready", n_pready - base_rdy, 0);
        check("stall_not_done", done, 0);
        adv_hold = 0;
      end
    join
    check("stall_pslverr", er, 0);
    check("stall_prdata", rd, 0);
    check_tx("stall", 1'b1, 32'h5000_0010, 32'h0F0F_1234);

    // Randomized traffic against the remote-memory model.
    adv_rand = 1;
    base_inv = n_invalid;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 32'h6000_0000 + 32'($urandom_range(0, 7) << 2);
      wd = $urandom;
      apb_xfer(wr, a, wd, rd, er, cyc);
      if (wr) begin
        model_mem[a] = wd;
        exp_rd = 32'd0;
      end else begin
        exp_rd = model_mem.exists(a) ? model_mem[a] : rule_dflt(a);
      end
      check($sformatf("rnd%0d_prdata", i), rd, exp_rd);
      check($sformatf("rnd%0d_pslverr", i), er, rule_err(a));
      check_tx($sformatf("rnd%0d", i), wr, a, wd);
    end
    check("rnd_no_invalid", n_invalid - base_inv, 0);
    adv_rand = 0;

    // Asynchronous reset while pready is high.
    enable = 1'b0;
    repeat (4) @(negedge apb_clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h1;
    @(negedge apb_clk);
    apb_penable = 1'b1;
    check("rstdone_pready_before", {apb_pready, apb_pslverr}, 2'b11);
    apb_reset = 1'b1; link_reset = 1'b1;
    #1;
    check("rstdone_pready", apb_pready, 0);
    check("rstdone_pslverr", apb_pslverr, 0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge apb_clk);
    apb_reset = 1'b0; link_reset = 1'b0; enable = 1'b1;
    repeat (4) @(negedge apb_clk);

    // Reset mid-wait discards the outstanding read; its late response is then dropped.
    auto_rsp = 0;
    @(negedge apb_clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 32'h6000_0004;
    @(negedge apb_clk);
    apb_penable = 1'b1;
    repeat (10) @(negedge apb_clk);
    apb_reset = 1'b1; link_reset = 1'b1;
    #1;
    check("rstwait_outputs", {apb_pready, apb_pslverr, apb_prdata, tx_sop}, 0);
    check("rstwait_pulses", {invalid_resp_pkt, timeout_err}, 0);
    apb_psel = 1'b0; apb_penable = 1'b0;
    repeat (2) @(negedge apb_clk);
    apb_reset = 1'b0; link_reset = 1'b0;
    tx_q.delete();
    repeat (3) @(negedge apb_clk);
    base_inv = n_invalid; base_rdy = n_pready;
    inj_q.push_back(mk_rsp(8'h25, 32'hBEEF_0002, 1'b0, 0));
    repeat (20) @(negedge apb_clk);
    check("rstwait_stale_dropped", n_invalid - base_inv, 1);
    check("rstwait_no_pready", n_pready - base_rdy, 0);

    // Recovery after reset.
    auto_rsp = 1;
    wd = 32'h1357_9BDF;
    apb_xfer(1'b1, 32'h6000_0004, wd, rd, er, cyc);
    check_tx("recov_wr", 1'b1, 32'h6000_0004, wd);
    apb_xfer(1'b0, 32'h6000_0004, 32'h0, rd, er, cyc);
    check("recov_prdata", rd, wd);
    check("recov_pslverr", er, 0);
    check_tx("recov_rd", 1'b0, 32'h6000_0004, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
